// File: rtl/kgp_mem_pkg.sv
// ============================================================================
// kgp_mem_pkg : shared definitions for the data-memory arbiter
// Rev 1.0     : initial release
// ============================================================================
`default_nettype none

package kgp_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    localparam logic PORT_C = 1'b0;
    localparam logic PORT_L = 1'b1;

    localparam int DMEM_ADDR_W = 12;

endpackage

`default_nettype wire

// File: rtl/rr_arb2.sv
// ============================================================================
// rr_arb2 : two-requester round-robin picker with one-hot grant
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module rr_arb2
    import kgp_mem_pkg::*;
(
    input  logic       clka,
    input  logic       rst_n,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic r_last;

    // On a tie the port that was not served last wins.
    always_comb begin
        gnt = 2'b00;
        if (en) begin
            if (req[0] && req[1]) begin
                gnt = (r_last == PORT_L) ? 2'b01 : 2'b10;
            end else begin
                gnt = req;
            end
        end
    end

    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= PORT_L;
        end else if (gnt[1]) begin
            r_last <= PORT_L;
        end else if (gnt[0]) begin
            r_last <= PORT_C;
        end
    end

endmodule

`default_nettype wire

// File: rtl/data_mem_arbiter.sv
// ============================================================================
// data_mem_arbiter : serialises CPU and loader accesses onto the data BRAM
// Rev 1.0          : initial release
// ============================================================================
`default_nettype none

module data_mem_arbiter
    import kgp_mem_pkg::*;
#(
    parameter int ADDR_W = DMEM_ADDR_W
) (
    input  logic        clka,
    input  logic        rst_n,

    input  logic        c_req,
    input  logic        c_we,
    input  logic [31:0] c_addr,
    input  logic [31:0] c_wdata,
    output logic        c_gnt,
    output logic        c_rvalid,
    output logic [31:0] c_rdata,
    output logic        c_err,

    input  logic        l_req,
    input  logic        l_we,
    input  logic [31:0] l_addr,
    input  logic [31:0] l_wdata,
    output logic        l_gnt,
    output logic        l_rvalid,
    output logic [31:0] l_rdata,
    output logic        l_err,

    output logic        mem_ena,
    output logic        mem_wea,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_din,
    input  logic [31:0] mem_dout,

    output logic        busy
);

    state_t      r_state;
    logic        r_port;
    logic        r_we;
    logic [1:0]  r_rvalid;
    logic [1:0]  r_err;
    logic [31:0] r_rdata [2];
    logic        r_mem_ena;
    logic        r_mem_wea;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_din;
    logic        r_busy;

    logic [1:0]  w_gnt;
    logic        w_win;
    logic        w_sel_we;
    logic [31:0] w_sel_addr;
    logic [31:0] w_sel_wdata;
    logic        w_in_range;

    rr_arb2 u_arb (
        .clka  (clka),
        .rst_n (rst_n),
        .en    (r_state == ST_IDLE),
        .req   ({l_req, c_req}),
        .gnt   (w_gnt)
    );

    assign w_win       = w_gnt[1];
    assign w_sel_we    = w_win ? l_we    : c_we;
    assign w_sel_addr  = w_win ? l_addr  : c_addr;
    assign w_sel_wdata = w_win ? l_wdata : c_wdata;
    assign w_in_range  = (w_sel_addr[31:ADDR_W] == '0);

    // rvalid/err are single-cycle pulses: cleared every cycle unless re-set.
    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_port     <= PORT_C;
            r_we       <= 1'b0;
            r_rvalid   <= 2'b00;
            r_err      <= 2'b00;
            r_rdata[0] <= '0;
            r_rdata[1] <= '0;
            r_mem_ena  <= 1'b0;
            r_mem_wea  <= 1'b0;
            r_mem_addr <= '0;
            r_mem_din  <= '0;
            r_busy     <= 1'b0;
        end else begin
            r_rvalid <= 2'b00;
            r_err    <= 2'b00;
            case (r_state)
                ST_IDLE: begin
                    if (|w_gnt) begin
                        r_port <= w_win;
                        r_we   <= w_sel_we;
                        r_busy <= 1'b1;
                        if (w_in_range) begin
                            r_state    <= ST_ACCESS;
                            r_mem_ena  <= 1'b1;
                            r_mem_wea  <= w_sel_we;
                            r_mem_addr <= {{(32-ADDR_W){1'b0}}, w_sel_addr[ADDR_W-1:0]};
                            r_mem_din  <= w_sel_wdata;
                        end else begin
                            r_state      <= ST_RESP;
                            r_err[w_win] <= 1'b1;
                            if (!w_sel_we) begin
                                r_rvalid[w_win] <= 1'b1;
                                r_rdata[w_win]  <= '0;
                            end
                        end
                    end
                end
                ST_ACCESS: begin
                    r_mem_ena <= 1'b0;
                    r_mem_wea <= 1'b0;
                    if (r_we) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    r_rdata[r_port]  <= mem_dout;
                    r_rvalid[r_port] <= 1'b1;
                    r_state          <= ST_RESP;
                end
                ST_RESP: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign c_gnt    = w_gnt[0];
    assign l_gnt    = w_gnt[1];
    assign c_rvalid = r_rvalid[0];
    assign l_rvalid = r_rvalid[1];
    assign c_err    = r_err[0];
    assign l_err    = r_err[1];
    assign c_rdata  = r_rdata[0];
    assign l_rdata  = r_rdata[1];
    assign mem_ena  = r_mem_ena;
    assign mem_wea  = r_mem_wea;
    assign mem_addr = r_mem_addr;
    assign mem_din  = r_mem_din;
    assign busy     = r_busy;

endmodule

`default_nettype wire
